// File: rtl/alu_operand_sequencer.sv
// Operand/opcode entry sequencer feeding the n-bit 4-op ALU.
// Captures A, B and a one-hot opcode on button rises; a finished result can be chained as the next A.
module alu_operand_sequencer #(
    parameter int n = 8
) (
    input  logic         clk,
    input  logic         resetN,
    input  logic [n-1:0] val,
    input  logic         enter,
    input  logic         undo,
    input  logic [3:0]   btn,
    input  logic [n-1:0] alu_result,
    output logic [n-1:0] op_a,
    output logic [n-1:0] op_b,
    output logic [3:0]   opcode,
    output logic [1:0]   stage,
    output logic         done
);

    typedef enum logic [1:0] {
        S_A   = 2'b00,
        S_B   = 2'b01,
        S_OP  = 2'b10,
        S_RES = 2'b11
    } state_t;

    state_t       state, state_nx;
    logic [n-1:0] op_a_nx, op_b_nx;
    logic [3:0]   opcode_nx;
    logic         done_nx;

    logic         enter_prev, undo_prev;
    logic [3:0]   btn_prev;
    logic         rise_enter, rise_undo;
    logic [3:0]   rise_btn;
    logic         btn_ok;

    assign rise_enter = enter & ~enter_prev;
    assign rise_undo  = undo & ~undo_prev;
    assign rise_btn   = btn & ~btn_prev;
    // Exactly one new press: nonzero and no second bit set.
    assign btn_ok     = (rise_btn != 4'b0000) && ((rise_btn & (rise_btn - 4'd1)) == 4'b0000);

    assign stage = state;

    // History resets to all-ones so levels held through reset release do not register as rises.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state      <= S_A;
            op_a       <= '0;
            op_b       <= '0;
            opcode     <= 4'b0000;
            done       <= 1'b0;
            enter_prev <= 1'b1;
            undo_prev  <= 1'b1;
            btn_prev   <= 4'b1111;
        end else begin
            state      <= state_nx;
            op_a       <= op_a_nx;
            op_b       <= op_b_nx;
            opcode     <= opcode_nx;
            done       <= done_nx;
            enter_prev <= enter;
            undo_prev  <= undo;
            btn_prev   <= btn;
        end
    end

    always_comb begin
        state_nx  = state;
        op_a_nx   = op_a;
        op_b_nx   = op_b;
        opcode_nx = opcode;
        done_nx   = 1'b0;
        case (state)
            S_A: begin
                if (rise_enter) begin
                    op_a_nx  = val;
                    state_nx = S_B;
                end
            end
            S_B: begin
                if (rise_enter) begin
                    op_b_nx  = val;
                    state_nx = S_OP;
                end else if (rise_undo) begin
                    op_a_nx  = '0;
                    state_nx = S_A;
                end
            end
            S_OP: begin
                if (rise_enter) begin
                    state_nx = S_OP;
                end else if (rise_undo) begin
                    op_b_nx  = '0;
                    state_nx = S_B;
                end else if (btn_ok) begin
                    opcode_nx = rise_btn;
                    state_nx  = S_RES;
                    done_nx   = 1'b1;
                end
            end
            S_RES: begin
                if (rise_enter) begin
                    op_a_nx   = '0;
                    op_b_nx   = '0;
                    opcode_nx = 4'b0000;
                    state_nx  = S_A;
                end else if (rise_undo) begin
                    opcode_nx = 4'b0000;
                    state_nx  = S_OP;
                end else if (btn_ok) begin
                    op_a_nx   = alu_result;
                    op_b_nx   = '0;
                    opcode_nx = 4'b0000;
                    state_nx  = S_B;
                end
            end
            default: state_nx = S_A;
        endcase
    end

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Scoreboard bench for alu_operand_sequencer with a behavioural ALU closing the chain loop.
module tb_alu_operand_sequencer;

    localparam int n = 8;

    logic         clk;
    logic         resetN;
    logic [n-1:0] val;
    logic         enter;
    logic         undo;
    logic [3:0]   btn;
    logic [n-1:0] alu_result;
    logic [n-1:0] op_a;
    logic [n-1:0] op_b;
    logic [3:0]   opcode;
    logic [1:0]   stage;
    logic         done;

    typedef struct {
        logic [n-1:0] a;
        logic [n-1:0] b;
        logic [3:0]   op;
        logic [1:0]   st;
        logic         d;
        int           id;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   step_id = 0;

    alu_operand_sequencer #(.n(n)) dut (
        .clk        (clk),
        .resetN     (resetN),
        .val        (val),
        .enter      (enter),
        .undo       (undo),
        .btn        (btn),
        .alu_result (alu_result),
        .op_a       (op_a),
        .op_b       (op_b),
        .opcode     (opcode),
        .stage      (stage),
        .done       (done)
    );

    // Reference ALU
    always_comb begin
        case (opcode)
            4'b1000: alu_result = op_a + op_b;
            4'b0100: alu_result = op_a - op_b;
            4'b0010: alu_result = op_a | op_b;
            4'b0001: alu_result = op_a & op_b;
            default: alu_result = '0;
        endcase
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_now(input string name, input exp_t e);
        total++;
        if (op_a !== e.a || op_b !== e.b || opcode !== e.op || stage !== e.st || done !== e.d) begin
            bad++;
            $display("FAIL %s#%0d got a=%h b=%h op=%b st=%b d=%b want a=%h b=%h op=%b st=%b d=%b",
                     name, e.id, op_a, op_b, opcode, stage, done, e.a, e.b, e.op, e.st, e.d);
        end
    endtask

    // Monitor: compare the state left by each active edge against the queued expectation.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) check_now("step", q.pop_front());
        end
    end

    // Drive inputs on the falling edge; the expectation applies after the next rising edge.
    task automatic step(input logic [n-1:0] v, input logic e, input logic u, input logic [3:0] b,
                        input logic [n-1:0] xa, input logic [n-1:0] xb, input logic [3:0] xop,
                        input logic [1:0] xst, input logic xd);
        exp_t x;
        @(negedge clk);
        val   = v;
        enter = e;
        undo  = u;
        btn   = b;
        step_id++;
        x.a = xa; x.b = xb; x.op = xop; x.st = xst; x.d = xd; x.id = step_id;
        q.push_back(x);
    endtask

    task automatic drain();
        int waited;
        waited = 0;
        while (q.size() > 0 && waited < 10) begin
            @(posedge clk);
            waited++;
        end
        #2;
        if (q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain left=%0d want 0", q.size());
            q.delete();
        end
    endtask

    initial begin
        exp_t z;
        z.a = '0; z.b = '0; z.op = 4'b0000; z.st = 2'b00; z.d = 1'b0; z.id = 0;
        resetN = 1'b0;
        val    = 8'h55;
        enter  = 1'b1;
        undo   = 1'b0;
        btn    = 4'b0000;
        repeat (3) @(posedge clk);
        #2;
        check_now("reset", z);

        @(negedge clk);
        resetN = 1'b1;
        // Enter held through reset release must not capture
        repeat (5) step(8'h55, 1, 0, 4'b0000, 8'h00, 8'h00, 4'b0000, 2'b00, 0);
        step(8'h12, 0, 0, 4'b0000, 8'h00, 8'h00, 4'b0000, 2'b00, 0);
        step(8'h12, 1, 0, 4'b0000, 8'h12, 8'h00, 4'b0000, 2'b01, 0);
        step(8'h12, 0, 0, 4'b0000, 8'h12, 8'h00, 4'b0000, 2'b01, 0);
        // Undo from S_B clears A
        step(8'h12, 0, 1, 4'b0000, 8'h00, 8'h00, 4'b0000, 2'b00, 0);
        step(8'h12, 0, 0, 4'b0000, 8'h00, 8'h00, 4'b0000, 2'b00, 0);

        // Full add 200+100
        step(8'd200, 1, 0, 4'b0000, 8'd200, 8'h00, 4'b0000, 2'b01, 0);
        step(8'd7,   0, 0, 4'b0000, 8'd200, 8'h00, 4'b0000, 2'b01, 0);
        step(8'd100, 1, 0, 4'b0000, 8'd200, 8'd100, 4'b0000, 2'b10, 0);
        step(8'd100, 0, 0, 4'b0000, 8'd200, 8'd100, 4'b0000, 2'b10, 0);
        step(8'd100, 0, 0, 4'b1000, 8'd200, 8'd100, 4'b1000, 2'b11, 1);
        step(8'd100, 0, 0, 4'b0000, 8'd200, 8'd100, 4'b1000, 2'b11, 0);
        drain();
        total++;
        if (alu_result !== 8'd44) begin
            bad++;
            $display("FAIL alu_sum got=%0d want=44", alu_result);
        end

        // Chain: DOWN takes result 44 as A
        step(8'd0,  0, 0, 4'b0100, 8'd44, 8'h00, 4'b0000, 2'b01, 0);
        step(8'd0,  0, 0, 4'b0000, 8'd44, 8'h00, 4'b0000, 2'b01, 0);
        step(8'd50, 1, 0, 4'b0000, 8'd44, 8'd50, 4'b0000, 2'b10, 0);
        step(8'd50, 0, 0, 4'b0000, 8'd44, 8'd50, 4'b0000, 2'b10, 0);
        step(8'd50, 0, 0, 4'b0010, 8'd44, 8'd50, 4'b0010, 2'b11, 1);
        step(8'd50, 0, 0, 4'b0000, 8'd44, 8'd50, 4'b0010, 2'b11, 0);

        // Back to S_OP; enter ignored there; invalid two-button press; LEFT while UP held
        step(8'd50, 0, 1, 4'b0000, 8'd44, 8'd50, 4'b0000, 2'b10, 0);
        step(8'd50, 0, 0, 4'b0000, 8'd44, 8'd50, 4'b0000, 2'b10, 0);
        step(8'd99, 1, 0, 4'b0000, 8'd44, 8'd50, 4'b0000, 2'b10, 0);
        step(8'd99, 0, 0, 4'b0000, 8'd44, 8'd50, 4'b0000, 2'b10, 0);
        step(8'd99, 0, 0, 4'b1001, 8'd44, 8'd50, 4'b0000, 2'b10, 0);
        step(8'd99, 0, 0, 4'b1000, 8'd44, 8'd50, 4'b0000, 2'b10, 0);
        step(8'd99, 0, 0, 4'b1001, 8'd44, 8'd50, 4'b0001, 2'b11, 1);
        step(8'd99, 0, 0, 4'b0000, 8'd44, 8'd50, 4'b0001, 2'b11, 0);

        // Enter in S_RES clears everything
        step(8'd99, 1, 0, 4'b0000, 8'h00, 8'h00, 4'b0000, 2'b00, 0);
        step(8'd99, 0, 0, 4'b0000, 8'h00, 8'h00, 4'b0000, 2'b00, 0);

        // Undo walk
        step(8'h0F, 1, 0, 4'b0000, 8'h0F, 8'h00, 4'b0000, 2'b01, 0);
        step(8'h0F, 0, 0, 4'b0000, 8'h0F, 8'h00, 4'b0000, 2'b01, 0);
        step(8'hF0, 1, 0, 4'b0000, 8'h0F, 8'hF0, 4'b0000, 2'b10, 0);
        step(8'hF0, 0, 0, 4'b0000, 8'h0F, 8'hF0, 4'b0000, 2'b10, 0);
        step(8'hF0, 0, 0, 4'b0001, 8'h0F, 8'hF0, 4'b0001, 2'b11, 1);
        step(8'hF0, 0, 0, 4'b0000, 8'h0F, 8'hF0, 4'b0001, 2'b11, 0);
        step(8'hF0, 0, 1, 4'b0000, 8'h0F, 8'hF0, 4'b0000, 2'b10, 0);
        step(8'hF0, 0, 0, 4'b0000, 8'h0F, 8'hF0, 4'b0000, 2'b10, 0);
        step(8'hF0, 0, 1, 4'b0000, 8'h0F, 8'h00, 4'b0000, 2'b01, 0);
        step(8'hF0, 0, 0, 4'b0000, 8'h0F, 8'h00, 4'b0000, 2'b01, 0);
        step(8'hF0, 0, 1, 4'b0000, 8'h00, 8'h00, 4'b0000, 2'b00, 0);
        step(8'hF0, 0, 0, 4'b0000, 8'h00, 8'h00, 4'b0000, 2'b00, 0);
        // Undo and op buttons ignored in S_A
        step(8'hF0, 0, 1, 4'b0100, 8'h00, 8'h00, 4'b0000, 2'b00, 0);
        step(8'hF0, 0, 0, 4'b0000, 8'h00, 8'h00, 4'b0000, 2'b00, 0);

        // Enter beats undo in S_B
        step(8'hAA, 1, 0, 4'b0000, 8'hAA, 8'h00, 4'b0000, 2'b01, 0);
        step(8'hAA, 0, 0, 4'b0000, 8'hAA, 8'h00, 4'b0000, 2'b01, 0);
        step(8'h44, 1, 1, 4'b0000, 8'hAA, 8'h44, 4'b0000, 2'b10, 0);
        step(8'h44, 0, 0, 4'b0000, 8'hAA, 8'h44, 4'b0000, 2'b10, 0);
        drain();

        // Asynchronous reset between clock edges in S_OP
        @(negedge clk);
        #2;
        resetN = 1'b0;
        #1;
        check_now("async_reset", z);
        @(negedge clk);
        resetN = 1'b1;
        repeat (2) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
